// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants and types for the byte-serial data-memory
// controller.
//   RST_ENABLE          active level of rst
//   ZERO_WORD           reset value of the load result
//   MEM_BYTE/HALF/WORD  size_i encodings (2'b11 behaves as a word)
//   state_e             controller FSM states
//   req_t               request fields latched at accept time
//   byte_count()        number of byte accesses for a size code
package mem_ctrl_pkg;

  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The address is kept outside the struct because its width is a
  // parameter of the top module.
  typedef struct packed {
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      MEM_BYTE: byte_count = 3'd1;
      MEM_HALF: byte_count = 3'd2;
      default:  byte_count = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// mem_ctrl_load_ext: sign/zero extension of an assembled load word.
//   asm_word  in  32  bytes gathered from RAM, byte 0 in bits 7:0
//   size      in  2   access size code
//   sext      in  1   1 = sign-extend byte/half, 0 = zero-extend
//   ext_word  out 32  extended result; word accesses pass through
module mem_ctrl_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] asm_word,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] ext_word
);

  always_comb begin
    ext_word = asm_word;
    case (size)
      MEM_BYTE: ext_word = {{24{sext & asm_word[7]}},  asm_word[7:0]};
      MEM_HALF: ext_word = {{16{sext & asm_word[15]}}, asm_word[15:0]};
      default:  ext_word = asm_word;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: services one 32-bit load/store from the MEM stage as a series of
// byte accesses on an 8-bit registered RAM port.
//   clk, rst            clock, synchronous active-high reset
//   req_i/we_i/addr_i/wdata_i/size_i/sext_i   request, held until done_o
//   rdata_o             load result, valid with done_o, held until next load
//   done_o              one-cycle completion pulse
//   busy_o              stall request, combinational from req_i in IDLE
//   mem_a_o/mem_dout_o/mem_wr_o/mem_din_i      byte RAM port
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic [7:0]        mem_dout_o,
  output logic              mem_wr_o,
  input  logic [7:0]        mem_din_i
);

  state_e            state_q, state_d;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        k_q;       // byte index: 0..N-1 issue, N = load drain
  logic [31:0]       asm_q;     // load bytes gathered so far
  logic [31:0]       asm_next;  // asm_q with this cycle's RAM byte merged in
  logic [31:0]       ext_word;
  logic [31:0]       rdata_q;
  logic [2:0]        nbytes;
  logic [1:0]        cap_idx;

  assign nbytes  = byte_count(req_q.size);
  // RAM data arriving now belongs to the byte issued last cycle.
  assign cap_idx = 2'(k_q - 3'd1);

  always_comb begin
    asm_next = asm_q;
    if (k_q != 3'd0)
      asm_next[{cap_idx, 3'b000} +: 8] = mem_din_i;
  end

  // Extend from asm_next so the final byte, captured on the drain edge,
  // is already part of the result that appears in DONE.
  mem_ctrl_load_ext u_load_ext (
    .asm_word (asm_next),
    .size     (req_q.size),
    .sext     (req_q.sext),
    .ext_word (ext_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_i) state_d = we_i ? ST_STORE : ST_LOAD;
      ST_STORE: if (k_q == nbytes - 3'd1) state_d = ST_DONE;
      ST_LOAD:  if (k_q == nbytes) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request latch, byte counter and load assembly
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      req_q   <= '0;
      addr_q  <= '0;
      k_q     <= '0;
      asm_q   <= '0;
      rdata_q <= ZERO_WORD;
    end else begin
      case (state_q)
        ST_IDLE: if (req_i) begin
          req_q.size  <= size_i;
          req_q.sext  <= sext_i;
          req_q.wdata <= wdata_i;
          addr_q      <= addr_i;
          k_q         <= '0;
          asm_q       <= '0;
        end
        ST_STORE: k_q <= k_q + 3'd1;
        ST_LOAD: begin
          k_q   <= k_q + 3'd1;
          asm_q <= asm_next;
          if (k_q == nbytes) rdata_q <= ext_word;
        end
        default: ;
      endcase
    end
  end

  assign rdata_o = rdata_q;

  // Output logic
  always_comb begin
    mem_a_o    = '0;
    mem_dout_o = '0;
    mem_wr_o   = 1'b0;
    done_o     = 1'b0;
    busy_o     = 1'b0;
    case (state_q)
      ST_IDLE: busy_o = req_i;
      ST_STORE: begin
        busy_o     = 1'b1;
        mem_wr_o   = 1'b1;
        mem_a_o    = addr_q + ADDR_W'(k_q);
        mem_dout_o = req_q.wdata[{k_q[1:0], 3'b000} +: 8];
      end
      ST_LOAD: begin
        busy_o = 1'b1;
        // Drain cycle (k == N) only captures; the port is quiet.
        if (k_q < nbytes) mem_a_o = addr_q + ADDR_W'(k_q);
      end
      ST_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a byte RAM model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, we_i, sext_i;
  logic [31:0] addr_i, wdata_i;
  logic [1:0]  size_i;
  logic [31:0] rdata_o;
  logic        done_o, busy_o;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_dout_o;
  logic        mem_wr_o;
  logic [7:0]  mem_din_i;

  int checks = 0;
  int failures = 0;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .size_i(size_i), .sext_i(sext_i), .rdata_o(rdata_o),
    .done_o(done_o), .busy_o(busy_o), .mem_a_o(mem_a_o),
    .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .mem_din_i(mem_din_i)
  );

  always #5 clk = ~clk;

  // 4 KiB registered byte RAM, addressed by the low 12 address bits,
  // with a backdoor write port for preloading.
  logic [7:0]  ram [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_a = '0;
  logic [7:0]  bd_d = '0;

  always @(posedge clk) begin
    if (bd_we)         ram[bd_a] <= bd_d;
    else if (mem_wr_o) ram[mem_a_o[11:0]] <= mem_dout_o;
    mem_din_i <= ram[mem_a_o[11:0]];
  end

  logic [31:0] ld_addr [0:15];

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    bd_a = a; bd_d = d; bd_we = 1'b1;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Drives one request from the current (IDLE) cycle, returns the cycle in
  // which done_o was seen (-1 on timeout), then steps into the IDLE cycle.
  task automatic run_req(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz,
                         input logic s, output logic [31:0] rd,
                         output int dc);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; size_i = sz; sext_i = s;
    dc = -1; rd = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c < 16) ld_addr[c] = mem_a_o;
      if (done_o) begin
        rd = rdata_o; dc = c;
        break;
      end
    end
    req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    size_i = '0; sext_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({done_o, mem_wr_o, busy_o} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got done/wr/busy=%b%b%b want 000", done_o, mem_wr_o, busy_o);
    end
    checks++;
    if (mem_a_o !== 32'h0 || mem_dout_o !== 8'h0) begin
      failures++;
      $display("FAIL reset_port got a=%h d=%h want 0/0", mem_a_o, mem_dout_o);
    end
    checks++;
    if (rdata_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got %h want 00000000", rdata_o);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({done_o, mem_wr_o, busy_o} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle got done/wr/busy=%b%b%b want 000", done_o, mem_wr_o, busy_o);
    end
  endtask

  task automatic test_word_store;
    logic [31:0] wd;
    wd = 32'h11223344;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h100; wdata_i = wd;
    size_i = 2'b10; sext_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b1) begin
      failures++;
      $display("FAIL store_busy_c0 got %b want 1", busy_o);
    end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_wr_o, mem_a_o, mem_dout_o, busy_o, done_o} !==
          {1'b1, 32'h100 + 32'(c - 1), 8'(wd >> (8 * (c - 1))), 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL store_c%0d got wr=%b a=%h d=%h busy=%b done=%b want 1 %h %h 1 0",
                 c, mem_wr_o, mem_a_o, mem_dout_o, busy_o, done_o,
                 32'h100 + 32'(c - 1), 8'(wd >> (8 * (c - 1))));
      end
    end
    @(negedge clk);
    checks++;
    if ({done_o, busy_o, mem_wr_o} !== 3'b100) begin
      failures++;
      $display("FAIL store_done_c5 got done/busy/wr=%b%b%b want 100", done_o, busy_o, mem_wr_o);
    end
    req_i = 1'b0;
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      failures++;
      $display("FAIL store_done_width got %b want 0", done_o);
    end
    checks++;
    if ({ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]} !== 32'h11223344) begin
      failures++;
      $display("FAIL store_ram got %h want 11223344",
               {ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]});
    end
  endtask

  task automatic test_byte_loads;
    logic [31:0] rd; int dc;
    poke(12'h200, 8'h80);
    poke(12'h201, 8'h7F);
    run_req(1'b0, 32'h200, 32'h0, 2'b00, 1'b1, rd, dc);
    checks++;
    if (rd !== 32'hFFFFFF80 || dc != 3) begin
      failures++;
      $display("FAIL lb got %h @%0d want ffffff80 @3", rd, dc);
    end
    run_req(1'b0, 32'h200, 32'h0, 2'b00, 1'b0, rd, dc);
    checks++;
    if (rd !== 32'h00000080 || dc != 3) begin
      failures++;
      $display("FAIL lbu got %h @%0d want 00000080 @3", rd, dc);
    end
  endtask

  task automatic test_half_loads;
    logic [31:0] rd; int dc;
    poke(12'h300, 8'hAA);
    poke(12'h301, 8'h34);
    poke(12'h302, 8'h92);
    poke(12'h303, 8'hBB);
    run_req(1'b0, 32'h301, 32'h0, 2'b01, 1'b1, rd, dc);
    checks++;
    if (rd !== 32'hFFFF9234 || dc != 4) begin
      failures++;
      $display("FAIL lh got %h @%0d want ffff9234 @4", rd, dc);
    end
    run_req(1'b0, 32'h301, 32'h0, 2'b01, 1'b0, rd, dc);
    checks++;
    if (rd !== 32'h00009234 || dc != 4) begin
      failures++;
      $display("FAIL lhu got %h @%0d want 00009234 @4", rd, dc);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd; int dc;
    poke(12'hFFE, 8'h01);
    poke(12'hFFF, 8'h02);
    poke(12'h000, 8'h03);
    poke(12'h001, 8'h84);
    run_req(1'b0, 32'hFFFFFFFE, 32'h0, 2'b11, 1'b0, rd, dc);
    checks++;
    if (rd !== 32'h84030201 || dc != 6) begin
      failures++;
      $display("FAIL wrap_data got %h @%0d want 84030201 @6", rd, dc);
    end
    checks++;
    if ({ld_addr[1], ld_addr[2], ld_addr[3], ld_addr[4]} !==
        {32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1}) begin
      failures++;
      $display("FAIL wrap_addr got %h %h %h %h want fffffffe ffffffff 0 1",
               ld_addr[1], ld_addr[2], ld_addr[3], ld_addr[4]);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; int dc; int ndone;
    run_req(1'b1, 32'h400, 32'hA1B2C3D4, 2'b10, 1'b0, rd, dc);
    checks++;
    if (dc != 5) begin
      failures++;
      $display("FAIL b2b_store_done got @%0d want @5", dc);
    end
    run_req(1'b0, 32'h400, 32'h0, 2'b10, 1'b1, rd, dc);
    checks++;
    if (rd !== 32'hA1B2C3D4 || dc != 6) begin
      failures++;
      $display("FAIL b2b_load got %h @%0d want a1b2c3d4 @6", rd, dc);
    end
    // Request held through DONE into the next IDLE cycle.
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h410; wdata_i = 32'h0000005A;
    size_i = 2'b00; sext_i = 1'b0; ndone = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({done_o, busy_o} !== 2'b10) begin
      failures++;
      $display("FAIL held_done got done/busy=%b%b want 10", done_o, busy_o);
    end
    if (done_o) ndone++;
    @(negedge clk);
    checks++;
    if ({mem_wr_o, busy_o, done_o} !== 3'b010) begin
      failures++;
      $display("FAIL held_idle got wr/busy/done=%b%b%b want 010", mem_wr_o, busy_o, done_o);
    end
    req_i = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    checks++;
    if (ndone != 1 || ram[12'h410] !== 8'h5A) begin
      failures++;
      $display("FAIL held_once got done_count=%0d ram=%h want 1 5a", ndone, ram[12'h410]);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int dc; int ndone;
    for (int i = 0; i < 4; i++) poke(12'h500 + 12'(i), 8'h00);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h500; wdata_i = 32'hDEADBEEF;
    size_i = 2'b10; sext_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_i = 1'b0;
    #1;
    checks++;
    if ({mem_wr_o, done_o, busy_o} !== 3'b000 || mem_a_o !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_idle got wr/done/busy=%b%b%b a=%h want 000 0",
               mem_wr_o, done_o, busy_o, mem_a_o);
    end
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL rstmid_nodone got %0d pulses want 0", ndone);
    end
    checks++;
    if ({ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]} !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL rstmid_ram got %h want 0000beef",
               {ram[12'h503], ram[12'h502], ram[12'h501], ram[12'h500]});
    end
    run_req(1'b0, 32'h100, 32'h0, 2'b10, 1'b0, rd, dc);
    checks++;
    if (rd !== 32'h11223344 || dc != 6) begin
      failures++;
      $display("FAIL rstmid_after got %h @%0d want 11223344 @6", rd, dc);
    end
  endtask

  initial begin
    test_reset;
    test_word_store;
    test_byte_loads;
    test_half_loads;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
